ucsbece154a_mem_arbiter: RTL

- Arbitrates the single unified instruction/data memory between two requesters.
- Requester 0 is the multicycle core (fetch, lw, sw); requester 1 is the aux port (debug loader / DMA).
- Owns the memory-side request/acknowledge handshake, so the memory may have variable latency.
- The core controller holds its FSM in the current memory state until core_ack_o.

---
 rtl/ucsbece154a_mem_arbiter_pkg.sv | 16 +
 rtl/ucsbece154a_arb_pick.sv | 72 +++++++
 rtl/ucsbece154a_mem_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ucsbece154a_mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encodings and grant IDs.
// Optional build macro MEM_ARB_RR_EN is consumed by ucsbece154a_arb_pick.
package ucsbece154a_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        arb_IDLE = 2'b00,
        arb_BUSY = 2'b01,
        arb_RESP = 2'b10
    } arb_state_t;

    localparam logic grant_core = 1'b0;
    localparam logic grant_aux  = 1'b1;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/ucsbece154a_arb_pick.sv
// Combinational winner selection between core and aux, plus the fairness state.
// Build macro: MEM_ARB_RR_EN selects round-robin; otherwise fixed priority with starvation guard.
module ucsbece154a_arb_pick
    import ucsbece154a_mem_arbiter_pkg::*;
#(
    parameter int AUX_STARVE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic core_req_i,
    input  logic aux_req_i,
    input  logic take_i,
    output logic winner_o
);

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        if (core_req_i && aux_req_i) begin
            winner_o = ~last_q;
        end else if (aux_req_i) begin
            winner_o = grant_aux;
        end else begin
            winner_o = grant_core;
        end
        last_d = take_i ? winner_o : last_q;
    end

    // Seeded as if aux went last, so the first conflict after reset goes to the core.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= grant_aux;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                conflict;

    assign conflict = core_req_i && aux_req_i;

    always_comb begin
        if (conflict) begin
            winner_o = (starve_q >= STARVE_W'(AUX_STARVE)) ? grant_aux : grant_core;
        end else if (aux_req_i) begin
            winner_o = grant_aux;
        end else begin
            winner_o = grant_core;
        end

        starve_d = starve_q;
        if (take_i) begin
            if (winner_o == grant_aux) begin
                starve_d = '0;
            end else if (conflict) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

endmodule

// File: rtl/ucsbece154a_mem_arbiter.sv
// Arbiter for the single unified instruction/data memory shared by the multicycle core and the aux port.
// Owns the variable-latency memory handshake; optional macro MEM_ARB_RR_EN selects round-robin picking.
module ucsbece154a_mem_arbiter
    import ucsbece154a_mem_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int AUX_STARVE = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_adr_i,
    input  logic [DW-1:0] core_wd_i,
    output logic [DW-1:0] core_rd_o,
    output logic          core_ack_o,

    input  logic          aux_req_i,
    input  logic          aux_we_i,
    input  logic [AW-1:0] aux_adr_i,
    input  logic [DW-1:0] aux_wd_i,
    output logic [DW-1:0] aux_rd_o,
    output logic          aux_ack_o,

    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_adr_o,
    output logic [DW-1:0] mem_wd_o,
    input  logic [DW-1:0] mem_rd_i,
    input  logic          mem_ack_i,

    output logic          grant_o
);

    arb_state_t    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_adr_q, mem_adr_d;
    logic [DW-1:0] mem_wd_q, mem_wd_d;
    logic          grant_q, grant_d;
    logic [DW-1:0] core_rd_q, core_rd_d;
    logic [DW-1:0] aux_rd_q, aux_rd_d;
    logic          core_ack_q, core_ack_d;
    logic          aux_ack_q, aux_ack_d;

    logic any_req;
    logic take;
    logic winner;

    assign any_req = core_req_i || aux_req_i;
    assign take    = (state_q == arb_IDLE) && any_req;

    ucsbece154a_arb_pick #(
        .AUX_STARVE(AUX_STARVE)
    ) u_pick (
        .clk       (clk),
        .reset     (reset),
        .core_req_i(core_req_i),
        .aux_req_i (aux_req_i),
        .take_i    (take),
        .winner_o  (winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= arb_IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_adr_q  <= '0;
            mem_wd_q   <= '0;
            grant_q    <= grant_core;
            core_rd_q  <= '0;
            aux_rd_q   <= '0;
            core_ack_q <= 1'b0;
            aux_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_adr_q  <= mem_adr_d;
            mem_wd_q   <= mem_wd_d;
            grant_q    <= grant_d;
            core_rd_q  <= core_rd_d;
            aux_rd_q   <= aux_rd_d;
            core_ack_q <= core_ack_d;
            aux_ack_q  <= aux_ack_d;
        end
    end

    // RESP lasts one cycle so a requester still holding req while seeing its ack is not granted twice.
    always_comb begin
        state_d = state_q;
        case (state_q)
            arb_IDLE: if (any_req)   state_d = arb_BUSY;
            arb_BUSY: if (mem_ack_i) state_d = arb_RESP;
            arb_RESP:                state_d = arb_IDLE;
            default:                 state_d = arb_IDLE;
        endcase
    end

    always_comb begin
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_adr_d  = mem_adr_q;
        mem_wd_d   = mem_wd_q;
        grant_d    = grant_q;
        core_rd_d  = core_rd_q;
        aux_rd_d   = aux_rd_q;
        core_ack_d = 1'b0;
        aux_ack_d  = 1'b0;
        case (state_q)
            arb_IDLE: begin
                if (any_req) begin
                    mem_req_d = 1'b1;
                    grant_d   = winner;
                    if (winner == grant_aux) begin
                        mem_we_d  = aux_we_i;
                        mem_adr_d = aux_adr_i;
                        mem_wd_d  = aux_wd_i;
                    end else begin
                        mem_we_d  = core_we_i;
                        mem_adr_d = core_adr_i;
                        mem_wd_d  = core_wd_i;
                    end
                end
            end
            arb_BUSY: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    if (grant_q == grant_aux) begin
                        aux_rd_d  = mem_rd_i;
                        aux_ack_d = 1'b1;
                    end else begin
                        core_rd_d  = mem_rd_i;
                        core_ack_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign mem_req_o  = mem_req_q;
    assign mem_we_o   = mem_we_q;
    assign mem_adr_o  = mem_adr_q;
    assign mem_wd_o   = mem_wd_q;
    assign grant_o    = grant_q;
    assign core_rd_o  = core_rd_q;
    assign aux_rd_o   = aux_rd_q;
    assign core_ack_o = core_ack_q;
    assign aux_ack_o  = aux_ack_q;

endmodule
